// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline M-stage and the data memory.
// Optional DMEM_MISALIGN_CHECK_EN adds the bad_store flag.
interface dmem_if;
    // Valid/ready: a request is taken on a rising edge where en=1 and ready=1;
    // requests offered while ready=0 are dropped, never stalled or queued.
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        bad_store;
`endif

    modport master (
        output en, wen, addr, wdata,
`ifdef DMEM_MISALIGN_CHECK_EN
        input  bad_store,
`endif
        input  rdata, ready
    );

    modport slave (
        input  en, wen, addr, wdata,
`ifdef DMEM_MISALIGN_CHECK_EN
        output bad_store,
`endif
        output rdata, ready
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with big-endian byte lanes, read-first, 1-cycle latency,
// and a post-reset clear sequencer. Optional macro DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output logic   o_dbg_state
);
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic [31:0]       r_mem [2**AW];

    logic [AW-1:0]     w_idx;
    logic              w_req;
    logic              w_clr;
    logic [3:0]        w_lane_we;
    logic              w_bad;
    logic              w_unused;

    assign w_idx    = bus.addr[AW+1:2];
    assign w_unused = &{1'b0, bus.addr};
    // rst wins on its own edge: no clear write and no request write then.
    assign w_req    = !rst && (r_state == S_READY) && bus.en;
    assign w_clr    = !rst && (r_state == S_CLEAR);

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic lane_legal(input logic [3:0] wen, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (wen)
            4'b1111: ok = (off == 2'b00);
            4'b1100: ok = (off == 2'b00);
            4'b0011: ok = (off == 2'b10);
            4'b1000: ok = (off == 2'b00);
            4'b0100: ok = (off == 2'b01);
            4'b0010: ok = (off == 2'b10);
            4'b0001: ok = (off == 2'b11);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic r_bad_store;

    assign w_bad         = w_req && (bus.wen != 4'b0000) && !lane_legal(bus.wen, bus.addr[1:0]);
    assign w_lane_we     = (w_req && !w_bad) ? bus.wen : 4'b0000;
    assign bus.bad_store = r_bad_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_store <= 1'b0;
        end else begin
            r_bad_store <= w_bad;
        end
    end
`else
    assign w_bad     = 1'b0;
    assign w_lane_we = w_req ? bus.wen : 4'b0000;
`endif

    // Storage has no reset; the clear sequencer is what makes it deterministic.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_cnt] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_cnt   <= '0;
            if (CLEAR_ON_RESET) begin
                r_state <= S_CLEAR;
                r_ready <= 1'b0;
            end else begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    // Nonblocking read of the array gives the pre-write word.
                    if (bus.en) begin
                        r_rdata <= r_mem[w_idx];
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata   = r_rdata;
    assign bus.ready   = r_ready;
    assign o_dbg_state = r_state;

    logic w_unused_bad;
    assign w_unused_bad = w_bad;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (AW=4, clear on reset), including the
// DMEM_MISALIGN_CHECK_EN build when that macro is defined.
module tb_dmem_responder;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    logic dbg_state;

    dmem_if bus ();

    dmem_responder #(.AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory as an array of words; after a reset the whole array is known zero
    // once DEPTH clear cycles have elapsed, and requests before that are lost.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_bad;
    int          clear_left;
    bit          model_live = 0;

    function automatic bit legal_pair(input logic [3:0] wen, input logic [1:0] off);
        return (wen == 4'b1111 && off == 0) || (wen == 4'b1100 && off == 0) ||
               (wen == 4'b0011 && off == 2) || (wen == 4'b1000 && off == 0) ||
               (wen == 4'b0100 && off == 1) || (wen == 4'b0010 && off == 2) ||
               (wen == 4'b0001 && off == 3);
    endfunction

    always @(posedge clk) begin
        int idx;
        logic [31:0] mask;
        bit allowed;
        if (rst) begin
            model_live = 1;
            exp_rdata  = 32'h0;
            exp_ready  = 1'b0;
            exp_bad    = 1'b0;
            clear_left = DEPTH;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
        end else if (model_live) begin
            exp_bad = 1'b0;
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) exp_ready = 1'b1;
            end else if (bus.en) begin
                idx       = int'(bus.addr >> 2) % DEPTH;
                exp_rdata = m_mem[idx];
                mask = 32'h0;
                if (bus.wen[3]) mask = mask | 32'hFF00_0000;
                if (bus.wen[2]) mask = mask | 32'h00FF_0000;
                if (bus.wen[1]) mask = mask | 32'h0000_FF00;
                if (bus.wen[0]) mask = mask | 32'h0000_00FF;
                allowed = 1;
`ifdef DMEM_MISALIGN_CHECK_EN
                if (bus.wen != 0 && !legal_pair(bus.wen, bus.addr[1:0])) begin
                    allowed = 0;
                    exp_bad = 1'b1;
                end
`endif
                if (allowed) m_mem[idx] = (m_mem[idx] & ~mask) | (bus.wdata & mask);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("ready", {31'h0, bus.ready}, {31'h0, exp_ready});
            chk("rdata", bus.rdata, exp_rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
            chk("bad_store", {31'h0, bus.bad_store}, {31'h0, exp_bad});
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.en = 1'b0; bus.wen = 4'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ready && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready still %b after %0d cycles, required 1", bus.ready, cycles);
        end
    endtask

    // Issue a read and return the word once the response edge has passed.
    task automatic read_word(input logic [31:0] a, output logic [31:0] q);
        drive(1'b1, 4'b0000, a, 32'h0);
        idle();
        q = bus.rdata;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic [31:0] q;
        rst = 1'b0;
        bus.en = 1'b0; bus.wen = 4'b0; bus.addr = 32'h0; bus.wdata = 32'h0;

        do_reset();
        chk("ready_low_after_reset", {31'h0, bus.ready}, 32'h0);
        chk("rdata_zero_after_reset", bus.rdata, 32'h0);
        wait_ready(cyc);
        chk("clear_cycles", cyc, 16);

        read_word(32'h3C, q);
        chk("lit_read_3c", q, 32'h0);

        drive(1'b1, 4'b1111, 32'h8, 32'h1234_5678);
        read_word(32'h8, q);
        chk("lit_full_word", q, 32'h1234_5678);

        drive(1'b1, 4'b0100, 32'h9, 32'hABAB_ABAB);
        read_word(32'h8, q);
        chk("lit_byte_lane", q, 32'h12AB_5678);

        drive(1'b1, 4'b0011, 32'hA, 32'hCDEF_CDEF);
        read_word(32'h8, q);
        chk("lit_half_lane", q, 32'h12AB_CDEF);

        drive(1'b1, 4'b1111, 32'h4, 32'hDEAD_BEEF);
        idle();
        chk("lit_read_first", bus.rdata, 32'h0);
        read_word(32'h4, q);
        chk("lit_after_write", q, 32'hDEAD_BEEF);

        drive(1'b1, 4'b1111, 32'h40, 32'h5A5A_5A5A);
        read_word(32'h0, q);
        chk("lit_alias", q, 32'h5A5A_5A5A);

        // en=0 with lanes enabled must not write
        drive(1'b0, 4'b1111, 32'h8, 32'hFFFF_FFFF);
        read_word(32'h8, q);
        chk("lit_en_low_ignored", q, 32'h12AB_CDEF);

`ifdef DMEM_MISALIGN_CHECK_EN
        drive(1'b1, 4'b1111, 32'h6, 32'h0102_0304);
        idle();
        chk("lit_bad_store_pulse", {31'h0, bus.bad_store}, 32'h1);
        chk("lit_bad_store_old", bus.rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lit_bad_store_one_cycle", {31'h0, bus.bad_store}, 32'h0);
        read_word(32'h4, q);
        chk("lit_suppressed", q, 32'hDEAD_BEEF);
        drive(1'b1, 4'b0011, 32'h6, 32'h0000_1111);
        idle();
        chk("lit_legal_no_flag", {31'h0, bus.bad_store}, 32'h0);
        read_word(32'h4, q);
        chk("lit_legal_write", q, 32'hDEAD_1111);
`else
        drive(1'b1, 4'b1111, 32'h6, 32'h0102_0304);
        read_word(32'h4, q);
        chk("lit_unchecked_write", q, 32'h0102_0304);
`endif

        // random mix, checked against the model every cycle
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  32'($urandom_range(0, 127)), $urandom);
        end
        idle();

        // reset with a request in flight, then reset again mid-clear
        drive(1'b1, 4'b1111, 32'h8, 32'h7777_7777);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.en = 1'b0;
        chk("rdata_zero_mid_op_reset", bus.rdata, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b1111, 32'h3C, 32'hFFFF_FFFF);
        do_reset();
        wait_ready(cyc);
        chk("clear_cycles_restart", cyc, 16);
        read_word(32'h8, q);
        chk("lit_cleared_again", q, 32'h0);
        read_word(32'h3C, q);
        chk("lit_clear_drop", q, 32'h0);

        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the pipeline's M-stage load/store interface.
- Accepts one request per cycle: word address, 4-bit byte-lane write enable, write data. Returns the full 32-bit word one cycle later.
- Lane mapping is big-endian, matching the pipeline's store encoding: wen[3] is byte address 0 and drives bits [31:24].
- Includes a post-reset clear sequencer so memory contents are deterministic before the core issues accesses.

Parameters:
- AW, 10, word-address width; depth = 2^AW words.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before asserting ready; 0 = ready immediately.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request valid this cycle.
- wen  input  4  byte write enables; wen[3] -> [31:24] ... wen[0] -> [7:0].
- addr  input  32  byte address; addr[AW+1:2] is the word index; addr[31:AW+2] and addr[1:0] are ignored for indexing.
- wdata  input  32  write data, already lane-replicated by the requester.
- rdata  output  32  registered read word.
- ready  output  1  high when requests are accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rdata <= 0; clear counter <= 0.
  - CLEAR_ON_RESET=1: state <= S_CLEAR, ready <= 0.
  - CLEAR_ON_RESET=0: state <= S_READY, ready <= 1.
  - Memory array is not touched by reset itself.
- S_CLEAR, each cycle:
  - Write 32'h0 to mem[cnt], then cnt <= cnt+1.
  - When cnt == 2^AW-1, that word is written and state <= S_READY, ready <= 1 on the same edge.
  - Clear takes exactly 2^AW cycles after the reset-release edge.
  - Requests in S_CLEAR are dropped: no write, rdata holds 0.
- S_READY, on an edge with en=1:
  - Each lane i with wen[i]=1 is written with the matching wdata lane; other lanes are unchanged.
  - rdata <= pre-write contents of mem[index] (read-first): a store returns the old word, a load returns the current word.
  - Latency: exactly 1 cycle from request edge to rdata valid.
- en=0: no write; rdata holds its previous value.
- wen≠0 with en=0: ignored.
- Back-to-back requests: a write at cycle N followed by a read of the same word at cycle N+1 returns the new data at N+2.
- Reset mid-clear or mid-operation: takes effect the same edge; clear restarts from cnt=0, and the in-flight request is discarded.
- Index wraps modulo 2^AW: upper address bits alias.
- State encoding: 1 bit. S_READY is terminal until the next rst.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: adds output port bad_store (1 bit, reset 0).
  - Legal (wen, addr[1:0]) pairs: 1111 with 00; 1100 with 00; 0011 with 10; 1000 with 00; 0100 with 01; 0010 with 10; 0001 with 11.
  - Any other nonzero wen with en=1 in S_READY: the write is suppressed, bad_store <= 1 for exactly one cycle, and rdata still returns the old word.
  - bad_store is 0 for all other cycles.
- Undefined: port absent; any nonzero wen pattern is written as given, regardless of addr[1:0].

Test Plan:
- Reset with CLEAR_ON_RESET=1, AW=4: ready stays 0 for 16 cycles after rst release, then goes 1. A read of addr 0x3C then returns 32'h0.
- In S_READY: write addr 0x8, wen=1111, wdata=32'h12345678. Next cycle read 0x8: rdata=32'h12345678 one cycle later.
- Starting from 0x8 = 32'h12345678:
  - wen=0100 at addr 0x9, wdata=32'hABABABAB -> read gives 32'h12AB5678.
  - Then wen=0011 at addr 0xA, wdata=32'hCDEFCDEF -> read gives 32'h12ABCDEF.
- Read-first: write addr 0x4 with 32'hDEADBEEF over 32'h0 -> rdata on the next cycle = 32'h0. The following read of 0x4 = 32'hDEADBEEF.
- Aliasing (AW=4): write 0x40 with 32'h5A5A5A5A -> read 0x0 returns 32'h5A5A5A5A.
- DMEM_MISALIGN_CHECK_EN defined: wen=1111 at addr 0x6 -> bad_store pulses 1 for one cycle and word 0x4 is unchanged. wen=0011 at addr 0x6 -> bad_store stays 0 and the write succeeds.
